// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// resolves branches from the ALU flags and counts retired instructions.
module cpu_control_fsm #(
   parameter logic [3:0] ALU_ADD = 4'h0,
   parameter logic [3:0] ALU_SUB = 4'h1,
   parameter int         CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [3:0]       opcode,
   input  logic             Zero,
   input  logic             Negative,
   input  logic             Overflow,
   output logic             pc_load,
   output logic             write_en,
   output logic             RW_,
   output logic             CS,
   output logic             OE,
   output logic             sel_rd,
   output logic             sel_alu_rt,
   output logic             sel_data_in,
   output logic [3:0]       alu_op,
   output logic             sel_branch,
   output logic             sel_jump,
   output logic             instr_done,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_BLT  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t           state_reg;
   logic [3:0]       op_reg;
   logic [CNT_W-1:0] instr_count_reg;

   logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_blt, is_branch, is_mem, branch_taken;

   // Everything after DECODE is steered by the latched opcode, not the live IR.
   assign is_rtype  = (op_reg < OP_ADDI);
   assign is_addi   = (op_reg == OP_ADDI);
   assign is_lw     = (op_reg == OP_LW);
   assign is_sw     = (op_reg == OP_SW);
   assign is_beq    = (op_reg == OP_BEQ);
   assign is_blt    = (op_reg == OP_BLT);
   assign is_branch = is_beq | is_blt;
   assign is_mem    = is_lw | is_sw;

   assign branch_taken = (is_beq & Zero) | (is_blt & (Negative ^ Overflow));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_FETCH;
         op_reg          <= '0;
         instr_count_reg <= '0;
      end else begin
         if (pc_load)
            instr_count_reg <= instr_count_reg + CNT_W'(1);
         case (state_reg)
            S_FETCH: begin
               if (run)
                  state_reg <= S_DECODE;
            end
            S_DECODE: begin
               op_reg <= opcode;
               if (opcode == OP_HALT)
                  state_reg <= S_HALT;
               else if (opcode >= OP_JMP)
                  state_reg <= S_FETCH;
               else
                  state_reg <= S_EXEC;
            end
            S_EXEC: begin
               if (is_rtype || is_addi)
                  state_reg <= S_WB;
               else if (is_mem)
                  state_reg <= S_MEM;
               else
                  state_reg <= S_FETCH;
            end
            S_MEM:   state_reg <= is_lw ? S_WB : S_FETCH;
            S_WB:    state_reg <= S_FETCH;
            S_HALT:  state_reg <= S_HALT;
            default: state_reg <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_load     = 1'b0;
      write_en    = 1'b0;
      RW_         = 1'b1;
      CS          = 1'b0;
      OE          = 1'b0;
      sel_rd      = 1'b0;
      sel_alu_rt  = 1'b0;
      sel_data_in = 1'b0;
      alu_op      = 4'h0;
      sel_branch  = 1'b0;
      sel_jump    = 1'b0;
      halted      = 1'b0;
      // Outputs are forced quiet while reset is held so no strobe escapes on the reset edge.
      if (reset) begin
         case (state_reg)
            S_FETCH: OE = 1'b1;
            S_DECODE: begin
               OE = 1'b1;
               if (opcode == OP_JMP) begin
                  sel_jump = 1'b1;
                  pc_load  = 1'b1;
               end else if (opcode > OP_JMP && opcode != OP_HALT) begin
                  pc_load = 1'b1;
               end
            end
            S_EXEC, S_MEM, S_WB: begin
               if (is_rtype)
                  alu_op = op_reg;
               else if (is_addi || is_mem)
                  alu_op = ALU_ADD;
               else if (is_branch)
                  alu_op = ALU_SUB;
               sel_rd      = is_rtype;
               sel_alu_rt  = is_addi | is_mem;
               sel_data_in = is_rtype | is_addi;
               if (state_reg == S_EXEC && is_branch) begin
                  pc_load    = 1'b1;
                  sel_branch = branch_taken;
               end
               if (state_reg == S_MEM) begin
                  CS      = 1'b1;
                  RW_     = is_lw;
                  pc_load = is_sw;
               end
               if (state_reg == S_WB) begin
                  write_en = 1'b1;
                  pc_load  = 1'b1;
                  CS       = is_lw;
               end
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign instr_done  = pc_load;
   assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm; a second instance with a 4-bit counter exercises wrap.
module tb_cpu_control_fsm;

   logic        clk = 1'b0;
   logic        reset, run, Zero, Negative, Overflow;
   logic [3:0]  opcode;

   logic        pc_load, write_en, RW_, CS, OE, sel_rd, sel_alu_rt, sel_data_in;
   logic [3:0]  alu_op;
   logic        sel_branch, sel_jump, instr_done, halted;
   logic [15:0] instr_count;

   logic        pc_load_w, write_en_w, RW_w, CS_w, OE_w, sel_rd_w, sel_alu_rt_w, sel_data_in_w;
   logic [3:0]  alu_op_w;
   logic        sel_branch_w, sel_jump_w, instr_done_w, halted_w;
   logic [3:0]  instr_count_w;

   int tests = 0;
   int fails = 0;

   logic [15:0] ctl;
   assign ctl = {pc_load, write_en, RW_, CS, OE, sel_rd, sel_alu_rt, sel_data_in,
                 alu_op, sel_branch, sel_jump, instr_done, halted};

   cpu_control_fsm dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode),
      .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
      .pc_load(pc_load), .write_en(write_en), .RW_(RW_), .CS(CS), .OE(OE),
      .sel_rd(sel_rd), .sel_alu_rt(sel_alu_rt), .sel_data_in(sel_data_in),
      .alu_op(alu_op), .sel_branch(sel_branch), .sel_jump(sel_jump),
      .instr_done(instr_done), .halted(halted), .instr_count(instr_count)
   );

   cpu_control_fsm #(.CNT_W(4)) dut_w (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode),
      .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
      .pc_load(pc_load_w), .write_en(write_en_w), .RW_(RW_w), .CS(CS_w), .OE(OE_w),
      .sel_rd(sel_rd_w), .sel_alu_rt(sel_alu_rt_w), .sel_data_in(sel_data_in_w),
      .alu_op(alu_op_w), .sel_branch(sel_branch_w), .sel_jump(sel_jump_w),
      .instr_done(instr_done_w), .halted(halted_w), .instr_count(instr_count_w)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ev(input bit pc, we, rw, cs, oe, rd, rt, din,
                                      input logic [3:0] alu, input bit br, jmp, done, hlt);
      return {pc, we, rw, cs, oe, rd, rt, din, alu, br, jmp, done, hlt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [15:0] exp);
      #1;
      chk(tag, {16'h0, ctl}, {16'h0, exp});
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] exp);
      #1;
      chk(tag, {16'h0, instr_count}, {16'h0, exp});
   endtask

   // Drive an opcode through FETCH and check the DECODE cycle outputs.
   task automatic do_fd(input string name, input logic [3:0] op, input logic [15:0] dec_exp);
      opcode = op;
      run    = 1'b1;
      chk_ctl({name, "_fetch"}, ev(0,0,1,0,1,0,0,0,4'h0,0,0,0,0));
      tick();
      chk_ctl({name, "_decode"}, dec_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] idle_v, fetch_v, nop_dec_v, halt_v, lw_exec_v;
      idle_v    = ev(0,0,1,0,0,0,0,0,4'h0,0,0,0,0);
      fetch_v   = ev(0,0,1,0,1,0,0,0,4'h0,0,0,0,0);
      nop_dec_v = ev(1,0,1,0,1,0,0,0,4'h0,0,0,1,0);
      halt_v    = ev(0,0,1,0,0,0,0,0,4'h0,0,0,0,1);
      lw_exec_v = ev(0,0,1,0,0,0,1,0,4'h0,0,0,0,0);

      reset = 1'b0; run = 1'b0; opcode = 4'h0;
      Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0;
      tick(); tick();
      chk_ctl("reset_outputs", idle_v);
      chk_cnt("reset_count", 16'd0);
      reset = 1'b1;
      chk_ctl("release_fetch", fetch_v);

      // ADD: opcode input scrambled after DECODE must not disturb the latched op
      do_fd("add", 4'h0, fetch_v);
      tick(); opcode = 4'hF;
      chk_ctl("add_exec", ev(0,0,1,0,0,1,0,1,4'h0,0,0,0,0));
      tick();
      chk_ctl("add_wb", ev(1,1,1,0,0,1,0,1,4'h0,0,0,1,0));
      tick();
      chk_cnt("add_count", 16'd1);

      do_fd("xor", 4'h4, fetch_v);
      tick();
      chk_ctl("xor_exec", ev(0,0,1,0,0,1,0,1,4'h4,0,0,0,0));
      tick();
      chk_ctl("xor_wb", ev(1,1,1,0,0,1,0,1,4'h4,0,0,1,0));
      tick();
      chk_cnt("xor_count", 16'd2);

      do_fd("lw", 4'h8, fetch_v);
      tick();
      chk_ctl("lw_exec", lw_exec_v);
      tick();
      chk_ctl("lw_mem", ev(0,0,1,1,0,0,1,0,4'h0,0,0,0,0));
      tick();
      chk_ctl("lw_wb", ev(1,1,1,1,0,0,1,0,4'h0,0,0,1,0));
      tick();
      chk_cnt("lw_count", 16'd3);

      do_fd("sw", 4'h9, fetch_v);
      tick();
      chk_ctl("sw_exec", lw_exec_v);
      tick();
      chk_ctl("sw_mem", ev(1,0,0,1,0,0,1,0,4'h0,0,0,1,0));
      tick();
      chk_ctl("sw_back_fetch", fetch_v);
      chk_cnt("sw_count", 16'd4);

      do_fd("beq_t", 4'hA, fetch_v);
      tick(); Zero = 1'b1;
      chk_ctl("beq_taken", ev(1,0,1,0,0,0,0,0,4'h1,1,0,1,0));
      tick(); Zero = 1'b0;
      do_fd("beq_nt", 4'hA, fetch_v);
      tick();
      chk_ctl("beq_not_taken", ev(1,0,1,0,0,0,0,0,4'h1,0,0,1,0));
      tick();

      // BLT 3<5: N=1 V=0 taken; 5<3: N=0 V=0 not taken; 0x7FFF<0x8000: N=1 V=1 not taken
      do_fd("blt_t", 4'hB, fetch_v);
      tick(); Negative = 1'b1; Overflow = 1'b0;
      chk_ctl("blt_3_lt_5", ev(1,0,1,0,0,0,0,0,4'h1,1,0,1,0));
      tick(); Negative = 1'b0;
      do_fd("blt_nt", 4'hB, fetch_v);
      tick();
      chk_ctl("blt_5_lt_3", ev(1,0,1,0,0,0,0,0,4'h1,0,0,1,0));
      tick();
      do_fd("blt_ovf", 4'hB, fetch_v);
      tick(); Negative = 1'b1; Overflow = 1'b1;
      chk_ctl("blt_overflow", ev(1,0,1,0,0,0,0,0,4'h1,0,0,1,0));
      tick(); Negative = 1'b0; Overflow = 1'b0;
      chk_cnt("branch_count", 16'd9);

      do_fd("jmp", 4'hC, ev(1,0,1,0,1,0,0,0,4'h0,0,1,1,0));
      tick();
      do_fd("nop", 4'hD, nop_dec_v);
      tick();
      chk_cnt("jmp_nop_count", 16'd11);

      run = 1'b0; opcode = 4'hF;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_ctl("stall_fetch", fetch_v);
      end
      chk_cnt("stall_count", 16'd11);
      chk("small_count_11", {28'h0, instr_count_w}, 32'd11);

      for (int i = 0; i < 5; i++) begin
         do_fd("nop_wrap", 4'hE, nop_dec_v);
         tick();
      end
      chk_cnt("count_16", 16'd16);
      chk("small_count_wrap", {28'h0, instr_count_w}, 32'd0);

      // Reset asserted in the MEM cycle of a load
      do_fd("lw_rst", 4'h8, fetch_v);
      tick();
      tick();
      chk_ctl("lw_rst_mem", ev(0,0,1,1,0,0,1,0,4'h0,0,0,0,0));
      reset = 1'b0;
      chk_ctl("reset_mid_lw", idle_v);
      chk_cnt("reset_mid_lw_count", 16'd0);
      tick();
      chk_ctl("reset_held", idle_v);
      reset = 1'b1;
      chk_ctl("reset_release_fetch", fetch_v);
      chk("small_count_reset", {28'h0, instr_count_w}, 32'd0);

      do_fd("halt", 4'hF, fetch_v);
      tick();
      for (int i = 0; i < 5; i++) begin
         run = i[0]; opcode = 4'hD;
         chk_ctl("halt_stays", halt_v);
         tick();
      end
      chk_cnt("halt_count", 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
